// File: rtl/flag_reg_unit.sv
// Committed NZCV flag register with an optional shadow copy for save/restore.
// Shadow register and its FSM are built only when FLAG_SHADOW_EN is defined.
module flag_reg_unit (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagWE,
    input  logic       CondExE,
    input  logic       StallE,
    input  logic       FlushE,
    input  logic       SaveReq,
    input  logic       RestoreReq,
    output logic [3:0] Flags,
    output logic [3:0] ShadowFlags,
    output logic       Busy,
    output logic       SaveAck,
    output logic       RestoreAck
);

    logic [3:0] flags_q, flags_d;
    logic       commit;

`ifdef FLAG_SHADOW_EN
    typedef enum logic [1:0] {
        IDLE,
        SAVE,
        RESTORE,
        ACK
    } state_t;

    state_t     state_q, state_d;
    logic       op_save_q, op_save_d;
    logic [3:0] shadow_q, shadow_d;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            op_save_q <= 1'b0;
            flags_q   <= 4'b0000;
            shadow_q  <= 4'b0000;
        end else begin
            state_q   <= state_d;
            op_save_q <= op_save_d;
            flags_q   <= flags_d;
            shadow_q  <= shadow_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_save_d = op_save_q;
        flags_d   = flags_q;
        shadow_d  = shadow_q;
        commit    = CondExE & ~StallE & ~FlushE & (state_q == IDLE);

        if (commit && FlagWE[1]) flags_d[3:2] = ALUFlags[3:2];
        if (commit && FlagWE[0]) flags_d[1:0] = ALUFlags[1:0];

        unique case (state_q)
            IDLE: begin
                // Save wins when both requests arrive together.
                if (SaveReq) begin
                    state_d   = SAVE;
                    op_save_d = 1'b1;
                end else if (RestoreReq) begin
                    state_d   = RESTORE;
                    op_save_d = 1'b0;
                end
            end
            SAVE: begin
                shadow_d = flags_q;
                state_d  = ACK;
            end
            RESTORE: begin
                flags_d = shadow_q;
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign Flags       = flags_q;
    assign ShadowFlags = shadow_q;
    assign Busy        = (state_q != IDLE);
    assign SaveAck     = (state_q == ACK) &  op_save_q;
    assign RestoreAck  = (state_q == ACK) & ~op_save_q;
`else
    logic unused_req;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    always_comb begin
        flags_d = flags_q;
        commit  = CondExE & ~StallE & ~FlushE;
        if (commit && FlagWE[1]) flags_d[3:2] = ALUFlags[3:2];
        if (commit && FlagWE[0]) flags_d[1:0] = ALUFlags[1:0];
    end

    assign unused_req  = SaveReq ^ RestoreReq;
    assign Flags       = flags_q;
    assign ShadowFlags = 4'b0000;
    assign Busy        = 1'b0;
    assign SaveAck     = 1'b0;
    assign RestoreAck  = 1'b0;
`endif

endmodule

// File: tb/tb_flag_reg_unit.sv
// Self-checking bench for flag_reg_unit: spec-level model compared every
// cycle, plus directed vectors with literal expectations (FLAG_SHADOW_EN aware).
module tb_flag_reg_unit;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [3:0] ALUFlags = '0;
    logic [1:0] FlagWE = '0;
    logic       CondExE = 1'b0;
    logic       StallE = 1'b0;
    logic       FlushE = 1'b0;
    logic       SaveReq = 1'b0;
    logic       RestoreReq = 1'b0;
    logic [3:0] Flags;
    logic [3:0] ShadowFlags;
    logic       Busy;
    logic       SaveAck;
    logic       RestoreAck;

    int checks = 0;
    int failures = 0;

    flag_reg_unit dut (
        .CLK(CLK),
        .RESET(RESET),
        .ALUFlags(ALUFlags),
        .FlagWE(FlagWE),
        .CondExE(CondExE),
        .StallE(StallE),
        .FlushE(FlushE),
        .SaveReq(SaveReq),
        .RestoreReq(RestoreReq),
        .Flags(Flags),
        .ShadowFlags(ShadowFlags),
        .Busy(Busy),
        .SaveAck(SaveAck),
        .RestoreAck(RestoreAck)
    );

    always #5 CLK = ~CLK;

    // Model: an operation occupies a fixed number of cycles after its
    // request edge; the op's effect lands at the end of its first busy cycle.
    logic [3:0] m_flags;
    logic [3:0] m_shadow;
    int         m_left;
    bit         m_is_save;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_flags  = 4'b0000;
            m_shadow = 4'b0000;
            m_left   = 0;
            m_is_save = 1'b0;
        end else begin
`ifdef FLAG_SHADOW_EN
            if (m_left == 0) begin
                if (CondExE && !StallE && !FlushE) begin
                    if (FlagWE[1]) m_flags[3:2] = ALUFlags[3:2];
                    if (FlagWE[0]) m_flags[1:0] = ALUFlags[1:0];
                end
                if (SaveReq || RestoreReq) begin
                    m_is_save = SaveReq;
                    m_left    = 2;
                end
            end else begin
                if (m_left == 2) begin
                    if (m_is_save) m_shadow = m_flags;
                    else           m_flags  = m_shadow;
                end
                m_left = m_left - 1;
            end
`else
            if (CondExE && !StallE && !FlushE) begin
                if (FlagWE[1]) m_flags[3:2] = ALUFlags[3:2];
                if (FlagWE[0]) m_flags[1:0] = ALUFlags[1:0];
            end
`endif
        end
    end

    task automatic chk(input string name, input logic [3:0] got,
                       input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp,
                     $time);
        end
    endtask

    always @(negedge CLK) begin
        chk("cyc_flags", Flags, m_flags);
        chk("cyc_shadow", ShadowFlags, m_shadow);
        chk("cyc_busy", {3'b0, Busy}, {3'b0, m_left != 0});
        chk("cyc_saveack", {3'b0, SaveAck},
            {3'b0, (m_left == 1) && m_is_save});
        chk("cyc_restack", {3'b0, RestoreAck},
            {3'b0, (m_left == 1) && !m_is_save});
    end

    task automatic drive(input logic [3:0] alu, input logic [1:0] we,
                         input logic c, input logic s, input logic f,
                         input logic sr, input logic rr);
        ALUFlags   = alu;
        FlagWE     = we;
        CondExE    = c;
        StallE     = s;
        FlushE     = f;
        SaveReq    = sr;
        RestoreReq = rr;
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic idle();
        drive(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    int n;
    int acks_s;
    int acks_r;

    initial begin
        #3;
        chk("rst_flags", Flags, 4'b0000);
        chk("rst_shadow", ShadowFlags, 4'b0000);
        chk("rst_ctl", {1'b0, Busy, SaveAck, RestoreAck}, 4'b0000);
        tick();
        tick();
        RESET = 1'b0;

        // Full and partial flag writes
        drive(4'b1010, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("write_full", Flags, 4'b1010);
        drive(4'b0101, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("write_cv", Flags, 4'b1001);
        drive(4'b0101, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("write_nz", Flags, 4'b0101);

        // Gating: condition fail, stall, flush
        drive(4'b1010, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("gate_cond", Flags, 4'b0101);
        drive(4'b1010, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("gate_stall", Flags, 4'b0101);
        drive(4'b1010, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("gate_flush", Flags, 4'b0101);
        drive(4'b1010, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("gate_we0", Flags, 4'b0101);

`ifdef FLAG_SHADOW_EN
        // Save 0110, commit attempt while busy is ignored
        drive(4'b0110, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("pre_save", Flags, 4'b0110);
        drive(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        n = 1;
        acks_s = 0;
        chk("save_busy", {3'b0, Busy}, 4'b0001);
        drive(4'b1111, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        while (Busy && n < 10) begin
            if (SaveAck) acks_s++;
            tick();
            n++;
        end
        idle();
        chk("save_edges", n[3:0], 4'd3);
        chk("save_ack_n", acks_s[3:0], 4'd1);
        chk("save_shadow", ShadowFlags, 4'b0110);
        chk("save_flags", Flags, 4'b0110);

        drive(4'b1111, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("pre_rest", Flags, 4'b1111);
        drive(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        n = 1;
        acks_r = 0;
        while (Busy && n < 10) begin
            if (RestoreAck) acks_r++;
            tick();
            n++;
        end
        chk("rest_edges", n[3:0], 4'd3);
        chk("rest_ack_n", acks_r[3:0], 4'd1);
        chk("rest_flags", Flags, 4'b0110);

        // Commit coinciding with SaveReq is captured by the save
        drive(4'b1100, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        tick();
        chk("co_shadow", ShadowFlags, 4'b1100);
        chk("co_flags", Flags, 4'b1100);

        // Both requests: save only
        drive(4'b0011, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        idle();
        tick();
        chk("both_acks", {2'b0, SaveAck, RestoreAck}, 4'b0010);
        tick();
        chk("both_flags", Flags, 4'b0011);
        chk("both_shadow", ShadowFlags, 4'b0011);

        // Reset during RESTORE
        drive(4'b1001, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        chk("mid_busy", {3'b0, Busy}, 4'b0001);
        RESET = 1'b1;
        #1;
        chk("mid_flags", Flags, 4'b0000);
        chk("mid_shadow", ShadowFlags, 4'b0000);
        chk("mid_ctl", {1'b0, Busy, SaveAck, RestoreAck}, 4'b0000);
        tick();
        chk("mid_noack", {3'b0, RestoreAck}, 4'b0000);
        RESET = 1'b0;
        tick();
        chk("mid_after", {1'b0, Busy, SaveAck, RestoreAck}, 4'b0000);
        chk("mid_flags2", Flags, 4'b0000);
`else
        // Requests ignored; commit still applies alongside them
        drive(4'b0110, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        chk("nos_flags", Flags, 4'b0110);
        chk("nos_ctl", {1'b0, Busy, SaveAck, RestoreAck}, 4'b0000);
        drive(4'b1111, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("nos_commit", Flags, 4'b1111);
        idle();
        tick();
        chk("nos_shadow", ShadowFlags, 4'b0000);
        chk("nos_idle", {1'b0, Busy, SaveAck, RestoreAck}, 4'b0000);
        drive(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("nos_rest", Flags, 4'b1111);
        idle();
        RESET = 1'b1;
        #1;
        chk("nos_reset", Flags, 4'b0000);
        tick();
        RESET = 1'b0;
        tick();
        chk("nos_after", Flags, 4'b0000);
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
